dspm_bus_bridge: RTL

DSPM_BUS_BRIDGE -- requirements
Module: dspm_bus_bridge

---
 rtl/dspm_pkg.sv | 20 ++
 rtl/dspm_resp_fifo.sv | 64 ++++++
 rtl/dspm_bus_bridge.sv | 103 ++++++++++
 3 files changed

// File: rtl/dspm_pkg.sv
// Shared DSpm bridge definitions: bus geometry and response/tag record types.
package dspm_pkg;

    localparam int WADDR_W   = 12;
    localparam int DATA_W    = 32;
    localparam int NUM_BYTES = 4;

    // One buffered response: 33 bits, err on top.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    // Attributes of the request issued last cycle, needed to form its response.
    typedef struct packed {
        logic write;
        logic err;
    } tag_t;

endpackage

// File: rtl/dspm_resp_fifo.sv
// Response buffer: DEPTH-entry circular FIFO of {err,rdata} records with a
// registered head. Output fields read as zero whenever the FIFO is empty.
module dspm_resp_fifo
    import dspm_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  resp_t            push_data,
    input  logic             pop,
    output logic             head_valid,
    output resp_t            head_data,
    output logic [CNT_W-1:0] count
);

    resp_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Circular-buffer index advance that wraps modulo DEPTH, power of two or not.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage write; the bridge never pushes into a full buffer.
    // NOTE: the storage array has no reset; its contents are only observable
    // through head_data, which is gated by head_valid, so stale entries never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push and pop together leave count unchanged.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dspm_bus_bridge.sv
// Request/response bridge onto a DSpm bus port. Aligned requests are issued to
// the DSpm in their accept cycle; the response is formed one cycle later from the
// DSpm read data and queued, so responses never appear combinationally.
module dspm_bus_bridge
    import dspm_pkg::DATA_W, dspm_pkg::NUM_BYTES, dspm_pkg::resp_t, dspm_pkg::tag_t;
#(
    parameter int DEPTH   = 2,                 // response-buffer entries, minimum 2
    parameter int WADDR_W = dspm_pkg::WADDR_W  // DSpm word-address width
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_req_valid,
    output logic                 io_req_ready,
    input  logic [WADDR_W+1:0]   io_req_addr,
    input  logic                 io_req_write,
    input  logic [DATA_W-1:0]    io_req_wdata,
    input  logic [NUM_BYTES-1:0] io_req_mask,
    output logic                 io_resp_valid,
    input  logic                 io_resp_ready,
    output logic [DATA_W-1:0]    io_resp_rdata,
    output logic                 io_resp_err,
    output logic [WADDR_W-1:0]   io_bus_addr,
    output logic                 io_bus_enable,
    output logic                 io_bus_byte_write_0,
    output logic                 io_bus_byte_write_1,
    output logic                 io_bus_byte_write_2,
    output logic                 io_bus_byte_write_3,
    output logic [DATA_W-1:0]    io_bus_data_in,
    input  logic [DATA_W-1:0]    io_bus_data_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             accept;
    logic             misaligned;
    logic             issue;
    logic             pop;
    logic             inflight;
    tag_t             tag_q;
    resp_t            push_data;
    resp_t            head;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;

    // Slots already committed after this cycle: buffered + in flight - leaving now.
    // pop implies count >= 1, so the subtraction never underflows.
    assign pop       = io_resp_valid && io_resp_ready;
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);

    // Gating with reset keeps the bus port quiet while reset is asserted.
    assign io_req_ready = reset && (occupancy < (CNT_W + 1)'(DEPTH));
    assign accept       = io_req_valid && io_req_ready;
    assign misaligned   = (io_req_addr[1:0] != 2'b00);
    assign issue        = accept && !misaligned;

    // Misaligned requests are accepted but never reach the DSpm.
    assign io_bus_addr         = io_req_addr[WADDR_W+1:2];
    assign io_bus_enable       = issue;
    assign io_bus_byte_write_0 = issue && io_req_write && io_req_mask[0];
    assign io_bus_byte_write_1 = issue && io_req_write && io_req_mask[1];
    assign io_bus_byte_write_2 = issue && io_req_write && io_req_mask[2];
    assign io_bus_byte_write_3 = issue && io_req_write && io_req_mask[3];
    assign io_bus_data_in      = io_req_wdata;

    // Remember that a request was accepted and how to turn it into a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            tag_q    <= '0;
        end else begin
            inflight    <= accept;
            tag_q.write <= io_req_write;
            tag_q.err   <= misaligned;
        end
    end

    // Response record for last cycle's request: only aligned loads carry data.
    // NOTE: every field gets a default first so this block can never infer a latch.
    always_comb begin
        push_data.err   = tag_q.err;
        push_data.rdata = '0;
        if (!tag_q.write && !tag_q.err) begin
            push_data.rdata = io_bus_data_out;
        end
    end

    dspm_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (io_resp_valid),
        .head_data  (head),
        .count      (count)
    );

    assign io_resp_rdata = head.rdata;
    assign io_resp_err   = head.err;

endmodule
